apb_lsu_bridge: RTL and testbench

//  Load/store unit that sits directly downstream of the multicycle datapath's data-memory port.

---
 rtl/apb_lsu_bridge_if.sv | 23 ++
 rtl/apb_lsu_bridge.sv | 180 ++++++++++++++++++
 tb/tb_apb_lsu_bridge.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_lsu_bridge_if.sv
// APB3 bus bundle between the load/store bridge (master) and the data-memory slave.
// Upper-case signal names match the APB3 signal names used on the memory side.
interface apb_lsu_bridge_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_lsu_bridge.sv
// Load/store unit: turns one control-unit request into one APB3 transfer, steering store
// bytes onto lanes and sign/zero-extending load data; ready pulses once per request.
//
// Handshake: req is a one-cycle pulse accepted only in IDLE (ignored elsewhere, including
// DONE); ready is a one-cycle pulse in DONE, with err and busRData valid alongside it.
module apb_lsu_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            func3,
    input  logic [31:0]           busAddr,
    input  logic [31:0]           busWData,
    output logic [31:0]           busRData,
    output logic                  ready,
    output logic                  err,
    output logic [1:0]            dbg_state,
    apb_lsu_bridge_if.master      apb
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        req_ok;
    logic        timeout_hit;
    logic [31:0] shifted;
    logic [31:0] load_fmt;
    logic [3:0]  strb_fmt;
    logic [31:0] wdata_fmt;

    // Legality of the incoming request: func3 encoding, store subset and natural alignment.
    always_comb begin
        req_ok = 1'b0;
        case (func3)
            3'b000:  req_ok = 1'b1;
            3'b001:  req_ok = ~busAddr[0];
            3'b010:  req_ok = (busAddr[1:0] == 2'b00);
            3'b100:  req_ok = ~we;
            3'b101:  req_ok = ~we & ~busAddr[0];
            default: req_ok = 1'b0;
        endcase
    end

    // cnt_q counts completed ACCESS cycles, so the Nth ACCESS cycle sees N-1.
    assign timeout_hit = (cnt_q == TO_LAST);

    always_comb begin
        shifted  = apb.PRDATA >> {addr_q[1:0], 3'b000};
        load_fmt = apb.PRDATA;
        case (f3_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_fmt = {24'h0, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_fmt = {16'h0, shifted[15:0]};
            default: load_fmt = apb.PRDATA;
        endcase
    end

    always_comb begin
        strb_fmt  = 4'b1111;
        wdata_fmt = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                strb_fmt  = 4'b0001 << addr_q[1:0];
                wdata_fmt = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb_fmt  = 4'b0011 << addr_q[1:0];
                wdata_fmt = {2{wdata_q[15:0]}};
            end
            default: begin
                strb_fmt  = 4'b1111;
                wdata_fmt = wdata_q;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req) state_d = req_ok ? S_SETUP : S_DONE;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (apb.PREADY || timeout_hit) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: bus fields are forced to zero outside SETUP/ACCESS.
    always_comb begin
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PADDR   = 32'h0;
        apb.PWDATA  = 32'h0;
        apb.PSTRB   = 4'b0000;
        apb.PWRITE  = 1'b0;
        ready       = 1'b0;
        err         = 1'b0;
        if (state_q == S_SETUP || state_q == S_ACCESS) begin
            apb.PSEL    = 1'b1;
            apb.PENABLE = (state_q == S_ACCESS);
            apb.PADDR   = {addr_q[31:2], 2'b00};
            apb.PWRITE  = we_q;
            apb.PWDATA  = we_q ? wdata_fmt : 32'h0;
            apb.PSTRB   = we_q ? strb_fmt : 4'b0000;
        end
        if (state_q == S_DONE) begin
            ready = 1'b1;
            err   = err_q;
        end
    end

    assign busRData  = rdata_q;
    assign dbg_state = state_q;

    // Request capture, completion status and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 16'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        f3_q    <= func3;
                        addr_q  <= busAddr;
                        wdata_q <= busWData;
                        if (!req_ok) begin
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end
                    end
                end
                S_SETUP: cnt_q <= 16'h0;
                S_ACCESS: begin
                    if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'h1;
                    if (apb.PREADY) begin
                        err_q   <= apb.PSLVERR;
                        rdata_q <= (we_q || apb.PSLVERR) ? 32'h0 : load_fmt;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_lsu_bridge.sv
// Bench for apb_lsu_bridge: directed cases then random transfers against a reference
// model computed from access size, byte offset and slave response.
module tb_apb_lsu_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [2:0]  func3;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        ready;
  logic        err;
  logic [1:0]  dbg_state;

  apb_lsu_bridge_if apb();

  apb_lsu_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .func3(func3),
    .busAddr(busAddr), .busWData(busWData), .busRData(busRData),
    .ready(ready), .err(err), .dbg_state(dbg_state), .apb(apb)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic int acc_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input logic w, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 0;
    if (w && f3 > 3'd2) return 0;
    sz = acc_size(f3);
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic w, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (!w) return 4'b0000;
    sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_pwdata(input logic w, input logic [2:0] f3, input logic [31:0] d);
    int sz;
    if (!w) return 32'h0;
    sz = acc_size(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] prd);
    logic [31:0] s;
    logic [31:0] v;
    s = prd >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = s & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFF_FF00; end
      3'd4: v = s & 32'hFF;
      3'd1: begin v = s & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
      3'd5: v = s & 32'hFFFF;
      default: v = prd;
    endcase
    return v;
  endfunction

  // One request; entered and left at a negedge with the DUT idle.
  task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int wait_n,
                         input logic [31:0] prd, input logic slv);
    bit ok;
    int n_acc;
    logic [31:0] exp_rd;
    logic        exp_err;
    ok = m_legal(w, f3, a);
    req = 1'b1; we = w; func3 = f3; busAddr = a; busWData = wd;
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = $urandom;
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); func3 = 3'($urandom); busAddr = $urandom; busWData = $urandom;
    if (!ok) begin
      exp_err = 1'b1;
      exp_rd  = 32'h0;
    end else begin
      chk("setup_psel", apb.PSEL, 1);
      chk("setup_penable", apb.PENABLE, 0);
      chk("setup_paddr", apb.PADDR, {a[31:2], 2'b00});
      chk("setup_pstrb", apb.PSTRB, m_strb(w, f3, a));
      chk("setup_pwdata", apb.PWDATA, m_pwdata(w, f3, wd));
      chk("setup_pwrite", apb.PWRITE, w);
      chk("setup_ready", ready, 0);
      n_acc = (wait_n < TO) ? wait_n + 1 : TO;
      for (int k = 0; k < n_acc; k++) begin
        @(negedge clk);
        apb.PREADY  = (k == wait_n);
        apb.PRDATA  = (k == wait_n) ? prd : $urandom;
        apb.PSLVERR = (k == wait_n) ? slv : 1'($urandom);
        req = 1'($urandom);
        chk("acc_psel", apb.PSEL, 1);
        chk("acc_penable", apb.PENABLE, 1);
        chk("acc_paddr", apb.PADDR, {a[31:2], 2'b00});
        chk("acc_pstrb", apb.PSTRB, m_strb(w, f3, a));
        chk("acc_pwdata", apb.PWDATA, m_pwdata(w, f3, wd));
        chk("acc_ready", ready, 0);
      end
      @(negedge clk);
      apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
      if (wait_n >= TO) begin
        exp_err = 1'b1;
        exp_rd  = 32'h0;
      end else begin
        exp_err = slv;
        exp_rd  = (w || slv) ? 32'h0 : m_load(f3, a, prd);
      end
    end
    chk("done_ready", ready, 1);
    chk("done_err", err, exp_err);
    chk("done_rdata", busRData, exp_rd);
    chk("done_psel", apb.PSEL, 0);
    last_rd = exp_rd;
    // A pulse during DONE must be dropped.
    req = 1'b1; we = 1'b0; func3 = 3'd2; busAddr = 32'h0;
    @(negedge clk);
    req = 1'b0;
    chk("idle_ready", ready, 0);
    chk("idle_psel", apb.PSEL, 0);
    chk("idle_paddr", apb.PADDR, 0);
    chk("idle_pstrb", apb.PSTRB, 0);
    chk("idle_rdata_held", busRData, last_rd);
    @(negedge clk);
    chk("idle2_psel", apb.PSEL, 0);
  endtask

  initial begin
    bit w;
    logic [2:0] f3;
    logic [31:0] a;
    reset = 1'b1; req = 1'b0; we = 1'b0; func3 = 3'd0; busAddr = 32'h0; busWData = 32'h0;
    apb.PRDATA = 32'h0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_state", dbg_state, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", busRData, 0);
    chk("rst_psel", apb.PSEL, 0);
    chk("rst_paddr", apb.PADDR, 0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1, 3'd2, 32'h1000_0008, 32'hDEAD_BEEF, 0, 32'h0, 0);
    run_txn(1, 3'd0, 32'h1000_0003, 32'h0000_00A5, 0, 32'h0, 0);
    run_txn(1, 3'd1, 32'h1000_0002, 32'h0000_BEEF, 1, 32'h0, 0);
    run_txn(0, 3'd0, 32'h1000_0001, 32'h0, 0, 32'h1234_80FF, 0);
    run_txn(0, 3'd4, 32'h1000_0001, 32'h0, 2, 32'h1234_80FF, 0);
    run_txn(0, 3'd5, 32'h1000_0002, 32'h0, 0, 32'h1234_80FF, 0);
    run_txn(0, 3'd2, 32'h1000_0002, 32'h0, 0, 32'h1234_80FF, 0);
    run_txn(0, 3'd2, 32'h1000_0004, 32'h0, 10, 32'h5555_AAAA, 0);
    run_txn(0, 3'd2, 32'h1000_0004, 32'h0, 1, 32'h5555_AAAA, 1);
    run_txn(1, 3'd4, 32'h1000_0004, 32'h0, 0, 32'h0, 0);
    run_txn(0, 3'd6, 32'h1000_0004, 32'h0, 0, 32'h0, 0);
    run_txn(0, 3'd1, 32'h1000_0006, 32'h0, 0, 32'hCAFE_F00D, 0);

    // Reset in the middle of ACCESS.
    req = 1'b1; we = 1'b0; func3 = 3'd2; busAddr = 32'h2000_0000;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("pre_rst_penable", apb.PENABLE, 1);
    reset = 1'b1;
    #1;
    chk("midrst_psel", apb.PSEL, 0);
    chk("midrst_penable", apb.PENABLE, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_rdata", busRData, 0);
    @(negedge clk);
    chk("midrst_ready2", ready, 0);
    reset = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    run_txn(0, 3'd2, 32'h2000_0010, 32'h0, 0, 32'h0BAD_CAFE, 0);

    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
      run_txn(w, f3, a, $urandom, $urandom_range(0, 5), $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
